// File: rtl/adder_arbiter.sv
// Round-robin sequencer sharing one 32-bit carry-lookahead adder
// among NUM_REQ requesters; one operation per three cycles.
module adder_cla (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cin,
    output logic [31:0] s,
    output logic        overflow
);
    logic [31:0] g;
    logic [31:0] p;
    logic [31:0] c;
    logic [7:0]  gc;

    assign g     = a & b;
    assign p     = a ^ b;
    assign gc[0] = cin;

    // 4-bit lookahead groups; group carries chain between groups
    for (genvar k = 0; k < 8; k++) begin : g_grp
        localparam int B = 4 * k;
        assign c[B]   = gc[k];
        assign c[B+1] = g[B] | (p[B] & c[B]);
        assign c[B+2] = g[B+1] | (p[B+1] & g[B])
                      | (p[B+1] & p[B] & c[B]);
        assign c[B+3] = g[B+2] | (p[B+2] & g[B+1])
                      | (p[B+2] & p[B+1] & g[B])
                      | (p[B+2] & p[B+1] & p[B] & c[B]);
        if (k < 7) begin : g_nxt
            assign gc[k+1] = g[B+3] | (p[B+3] & g[B+2])
                           | (p[B+3] & p[B+2] & g[B+1])
                           | (p[B+3] & p[B+2] & p[B+1] & g[B])
                           | (p[B+3] & p[B+2] & p[B+1] & p[B] & c[B]);
        end
    end

    assign s        = p ^ c;
    assign overflow = (~a[31] & ~b[31] & s[31])
                    | (a[31] & b[31] & ~s[31]);
endmodule

module adder_arbiter #(
    parameter int NUM_REQ = 4
) (
    input  logic                   clock,
    input  logic                   resetn,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [32*NUM_REQ-1:0]  op_a,
    input  logic [32*NUM_REQ-1:0]  op_b,
    input  logic [NUM_REQ-1:0]     sub,
    output logic [NUM_REQ-1:0]     grant,
    output logic [NUM_REQ-1:0]     done,
    output logic [31:0]            result,
    output logic                   overflow,
    output logic                   busy
);
    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

    state_t        state;
    logic [PW-1:0] ptr;
    logic [PW-1:0] win;
    logic [PW-1:0] pick;
    logic [PW-1:0] ptr_nxt;
    logic          any;
    logic [31:0]   a_q;
    logic [31:0]   b_q;
    logic          sub_q;
    logic [31:0]   sum;
    logic          ovf;

    // first requester at or after the pointer, wrapping
    always_comb begin
        int idx;
        idx  = 0;
        pick = '0;
        any  = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = (int'(ptr) + i) % NUM_REQ;
            if (!any && req[idx]) begin
                any  = 1'b1;
                pick = PW'(idx);
            end
        end
    end

    assign ptr_nxt = (win == PW'(NUM_REQ - 1)) ? '0 : win + 1'b1;
    assign busy    = (state != IDLE);

    adder_cla u_add (
        .a        (a_q),
        .b        (b_q ^ {32{sub_q}}),
        .cin      (sub_q),
        .s        (sum),
        .overflow (ovf)
    );

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state    <= IDLE;
            ptr      <= '0;
            win      <= '0;
            a_q      <= '0;
            b_q      <= '0;
            sub_q    <= 1'b0;
            grant    <= '0;
            done     <= '0;
            result   <= '0;
            overflow <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (any) begin
                        win   <= pick;
                        a_q   <= op_a[32*pick +: 32];
                        b_q   <= op_b[32*pick +: 32];
                        sub_q <= sub[pick];
                        grant <= NUM_REQ'(1) << pick;
                        state <= EXEC;
                    end
                end
                EXEC: begin
                    result   <= sum;
                    overflow <= ovf;
                    done     <= grant;
                    grant    <= '0;
                    ptr      <= ptr_nxt;
                    state    <= DONE;
                end
                DONE: begin
                    done  <= '0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_adder_arbiter.sv
// Directed bench for adder_arbiter: table of single-requester
// operations plus fairness, wrap and mid-operation reset sequences.
module tb_adder_arbiter;
    localparam int N = 4;

    logic            clock = 1'b0;
    logic            resetn;
    logic [N-1:0]    req;
    logic [32*N-1:0] op_a;
    logic [32*N-1:0] op_b;
    logic [N-1:0]    sub;
    logic [N-1:0]    grant;
    logic [N-1:0]    done;
    logic [31:0]     result;
    logic            overflow;
    logic            busy;

    int errors = 0;
    int checks = 0;

    adder_arbiter #(.NUM_REQ(N)) dut (
        .clock    (clock),
        .resetn   (resetn),
        .req      (req),
        .op_a     (op_a),
        .op_b     (op_b),
        .sub      (sub),
        .grant    (grant),
        .done     (done),
        .result   (result),
        .overflow (overflow),
        .busy     (busy)
    );

    always #5 clock = ~clock;

    typedef struct {
        int          lane;
        logic [31:0] a;
        logic [31:0] b;
        logic        s;
        logic [31:0] r;
        logic        o;
    } vec_t;

    vec_t tbl[8];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic set_lane(input int i, input logic [31:0] a,
                            input logic [31:0] b, input logic s);
        op_a[32*i +: 32] = a;
        op_b[32*i +: 32] = b;
        sub[i]           = s;
    endtask

    // called at a negedge in IDLE with req already raised
    task automatic step(input int k, input logic [31:0] r,
                        input logic o, input string tag);
        @(negedge clock);
        chk({tag, " grant"}, 32'(grant), 32'(1) << k);
        chk({tag, " busy"}, 32'(busy), 32'd1);
        chk({tag, " no done in exec"}, 32'(done), 32'd0);
        @(negedge clock);
        chk({tag, " done"}, 32'(done), 32'(1) << k);
        chk({tag, " grant low"}, 32'(grant), 32'd0);
        chk({tag, " result"}, result, r);
        chk({tag, " overflow"}, 32'(overflow), 32'(o));
        req[k] = 1'b0;
        @(negedge clock);
        chk({tag, " done cleared"}, 32'(done), 32'd0);
        chk({tag, " result hold"}, result, r);
    endtask

    initial begin
        tbl[0] = '{0, 32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b1};
        tbl[1] = '{2, 32'h00000005, 32'h00000007, 1'b1, 32'hFFFFFFFE, 1'b0};
        tbl[2] = '{1, 32'h80000000, 32'h00000001, 1'b1, 32'h7FFFFFFF, 1'b1};
        tbl[3] = '{3, 32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b0};
        tbl[4] = '{0, 32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b1};
        tbl[5] = '{3, 32'h00000000, 32'h80000000, 1'b1, 32'h80000000, 1'b1};
        tbl[6] = '{1, 32'h12345678, 32'h9ABCDEF0, 1'b0, 32'hACF13568, 1'b0};
        tbl[7] = '{2, 32'h00000007, 32'h00000007, 1'b1, 32'h00000000, 1'b0};

        resetn = 1'b0;
        req    = '0;
        op_a   = '0;
        op_b   = '0;
        sub    = '0;
        repeat (2) @(negedge clock);
        chk("reset grant", 32'(grant), 32'd0);
        chk("reset done", 32'(done), 32'd0);
        chk("reset result", result, 32'd0);
        chk("reset overflow", 32'(overflow), 32'd0);
        chk("reset busy", 32'(busy), 32'd0);
        resetn = 1'b1;
        @(negedge clock);
        chk("idle busy", 32'(busy), 32'd0);

        for (int v = 0; v < 8; v++) begin
            set_lane(tbl[v].lane, tbl[v].a, tbl[v].b, tbl[v].s);
            req[tbl[v].lane] = 1'b1;
            step(tbl[v].lane, tbl[v].r, tbl[v].o, $sformatf("vec%0d", v));
        end

        // fresh pointer: all four requesting
        resetn = 1'b0;
        @(negedge clock);
        resetn = 1'b1;
        for (int i = 0; i < N; i++) set_lane(i, 32'(i), 32'd100, 1'b0);
        req = 4'b1111;
        for (int k = 0; k < N; k++)
            step(k, 32'(100 + k), 1'b0, $sformatf("rr%0d", k));

        req = 4'b1001;
        step(0, 32'd100, 1'b0, "rr1001 first");
        step(3, 32'd103, 1'b0, "rr1001 second");

        req = 4'b0011;
        step(0, 32'd100, 1'b0, "wrap first");
        step(1, 32'd101, 1'b0, "wrap second");

        // pointer now 2: requester 2 wins over 0
        req = 4'b0101;
        step(2, 32'd102, 1'b0, "ptr2 first");
        step(0, 32'd100, 1'b0, "ptr2 second");

        // reset while requester 1 is in EXEC
        set_lane(1, 32'h80000000, 32'h00000001, 1'b1);
        req = 4'b0010;
        @(negedge clock);
        chk("abort grant before", 32'(grant), 32'b0010);
        #2;
        resetn = 1'b0;
        req    = '0;
        #1;
        chk("abort grant", 32'(grant), 32'd0);
        chk("abort done", 32'(done), 32'd0);
        chk("abort result", result, 32'd0);
        chk("abort overflow", 32'(overflow), 32'd0);
        chk("abort busy", 32'(busy), 32'd0);
        @(negedge clock);
        chk("abort no done", 32'(done), 32'd0);
        resetn = 1'b1;
        @(negedge clock);
        chk("post reset idle", 32'(busy), 32'd0);
        req = 4'b0010;
        step(1, 32'h7FFFFFFF, 1'b1, "after reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
